// File: rtl/spart_pkg.sv
// ============================================================================
// Module : spart_pkg
// Brief  : Shared register-address encoding and status bit positions for the
//          SPART bus bridge.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spart_pkg;

    localparam int DIV_W  = 16;
    localparam int ADDR_W = 2;

    typedef enum logic [ADDR_W-1:0] {
        ADDR_DATA   = 2'd0,
        ADDR_STATUS = 2'd1,
        ADDR_DIV_LO = 2'd2,
        ADDR_DIV_HI = 2'd3
    } spart_addr_e;

    localparam int STAT_RDA   = 0;
    localparam int STAT_TBR   = 1;
    localparam int STAT_OVR   = 2;
    localparam int STAT_IE_RX = 4;
    localparam int STAT_IE_TX = 5;

endpackage

`default_nettype wire

// File: rtl/spart_bus_bridge_if.sv
// ============================================================================
// Module : spart_bus_bridge_if
// Brief  : Processor access strobes plus receiver/transmitter handshakes
//          between the SPART bridge and its neighbours.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spart_bus_bridge_if;
    import spart_pkg::*;

    logic [ADDR_W-1:0] ioaddr;
    logic              iocs;
    logic              iorw;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              tbr;
    logic [7:0]        tx_data;
    logic              tx_write;

    modport master (
        output ioaddr, iocs, iorw, rx_data, rx_valid, tbr,
        input  tx_data, tx_write
    );

    modport slave (
        input  ioaddr, iocs, iorw, rx_data, rx_valid, tbr,
        output tx_data, tx_write
    );

endinterface

`default_nettype wire

// File: rtl/spart_bus_bridge_rx_fifo.sv
// ============================================================================
// Module : spart_rx_fifo
// Brief  : Show-ahead byte FIFO with registered full/empty flags; callers must
//          not push when full (unless popping) nor pop when empty.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [7:0]       din,
    output logic [7:0]       head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Flags are registered from count_next so rda never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/spart_bus_bridge.sv
// ============================================================================
// Module : spart_bus_bridge
// Brief  : Processor-side register bridge for the SPART: RX FIFO, TX data,
//          status/overrun and baud divisor. SPART_IRQ_EN adds the irq output.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spart_bus_bridge
    import spart_pkg::*;
#(
    parameter int               DATA_W    = 8,
    parameter int               RX_DEPTH  = 4,
    parameter logic [DIV_W-1:0] DIV_RESET = 16'd325
) (
    input  logic              clk,
    input  logic              rst_n,
    inout  wire  [DATA_W-1:0] databus,
    spart_bus_bridge_if.slave bus,
    output logic [DIV_W-1:0]  baud_div,
    output logic              baud_load,
    output logic              rda
`ifdef SPART_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int CNT_W = $clog2(RX_DEPTH) + 1;

    spart_addr_e       addr;
    logic              rd_access;
    logic              wr_access;
    logic [7:0]        wbyte;
    logic [DATA_W-1:0] rdata;
    logic [7:0]        status;
    logic [7:0]        div_lo;
    logic              overrun;
    logic              ie_rx;
    logic              ie_tx;

    logic              fifo_push;
    logic              fifo_pop;
    logic [7:0]        fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              ovr_set;
    logic              ovr_clr;

    assign addr      = spart_addr_e'(bus.ioaddr);
    assign rd_access = bus.iocs && bus.iorw;
    assign wr_access = bus.iocs && !bus.iorw;
    assign wbyte     = databus[7:0];

    // A full FIFO still accepts a byte when the same edge pops one.
    assign fifo_pop  = rd_access && (addr == ADDR_DATA) && !fifo_empty;
    assign fifo_push = bus.rx_valid && (!fifo_full || fifo_pop);
    assign ovr_set   = bus.rx_valid && fifo_full && !fifo_pop;
    assign ovr_clr   = wr_access && (addr == ADDR_STATUS) && wbyte[STAT_OVR];

    spart_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.rx_data),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rda = !fifo_empty;

    always_comb begin
        status             = '0;
        status[STAT_RDA]   = rda;
        status[STAT_TBR]   = bus.tbr;
        status[STAT_OVR]   = overrun;
        status[STAT_IE_RX] = ie_rx;
        status[STAT_IE_TX] = ie_tx;
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_DATA:   if (!fifo_empty) rdata[7:0] = fifo_head;
            ADDR_STATUS: rdata[7:0] = status;
            ADDR_DIV_LO: rdata[7:0] = baud_div[7:0];
            ADDR_DIV_HI: rdata[7:0] = baud_div[15:8];
            default:     rdata = '0;
        endcase
    end

    assign databus = rd_access ? rdata : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.tx_data  <= 8'h00;
            bus.tx_write <= 1'b0;
            baud_div     <= DIV_RESET;
            div_lo       <= DIV_RESET[7:0];
            baud_load    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            bus.tx_write <= 1'b0;
            baud_load    <= 1'b0;
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
            if (wr_access) begin
                case (addr)
                    ADDR_DATA: begin
                        bus.tx_data  <= wbyte;
                        bus.tx_write <= 1'b1;
                    end
                    ADDR_DIV_LO: div_lo <= wbyte;
                    ADDR_DIV_HI: begin
                        baud_div  <= {wbyte, div_lo};
                        baud_load <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SPART_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie_rx <= 1'b0;
            ie_tx <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (wr_access && (addr == ADDR_STATUS)) begin
                ie_rx <= wbyte[STAT_IE_RX];
                ie_tx <= wbyte[STAT_IE_TX];
            end
            irq <= (ie_rx && rda) || (ie_tx && bus.tbr);
        end
    end
`else
    assign ie_rx = 1'b0;
    assign ie_tx = 1'b0;
`endif

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= CNT_W'(RX_DEPTH));

endmodule

`default_nettype wire
